hidden_cpu_param: RTL and testbench

- Parametrised next-generation accumulator-style CPU for the tile.
- Executes one externally supplied instruction per clock from a register-file of `NREGS` × `DATA_W` words, with a `PC_W`-bit program counter.
- New over the fixed 8-bit/4-register core:
  - instruction-valid stall input
  - zero flag
  - conditional branch field
  - explicit output-latch instruction
  - halt state
- Sits directly behind the tile's input pins; `pc` and `dout` drive the output pins through the top-level wrapper.

---
 rtl/hidden_cpu_param.sv | 109 ++++++++++
 tb/tb_hidden_cpu_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hidden_cpu_param.sv
// Parametrised single-cycle accumulator CPU: register file, ALU, zero/borrow/carry flags, conditional branch, output latch, halt.
// Latency: one edge per valid instruction. Backpressure: instr_valid low or halted freezes all architectural state.
module hidden_cpu_param #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int PC_W   = 8,
    localparam int AW    = $clog2(NREGS),
    localparam int IW    = 3 + 2 * AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [IW-1:0]     instr,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] dout,
    output logic [2:0]        flags,
    output logic              halted
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_NAND = 3'd2,
        OP_MOV  = 3'd3,
        OP_LDI  = 3'd4,
        OP_BR   = 3'd5,
        OP_OUT  = 3'd6,
        OP_HALT = 3'd7
    } op_t;

    logic [DATA_W-1:0] regs [NREGS];
    logic              z_flag, b_flag, c_flag;

    op_t               op;
    logic [AW-1:0]     rd, rs;
    logic [DATA_W-1:0] a, b;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    logic              wr_en;
    logic [1:0]        cond;
    logic              br_taken;
    logic              exec;

    assign op   = op_t'(instr[IW-1 -: 3]);
    assign rd   = instr[2*AW-1 -: AW];
    assign rs   = instr[AW-1:0];
    assign a    = regs[rd];
    assign b    = regs[rs];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign exec = instr_valid && !halted;

    // Only the low two bits of rs select the branch condition; a 1-bit rs zero-extends.
    assign cond = 2'(rs);

    always_comb begin
        res   = '0;
        wr_en = 1'b0;
        case (op)
            OP_ADD:  begin res = sum[DATA_W-1:0]; wr_en = 1'b1; end
            OP_SUB:  begin res = a - b;           wr_en = 1'b1; end
            OP_NAND: begin res = ~(a & b);        wr_en = 1'b1; end
            OP_MOV:  begin res = b;               wr_en = 1'b1; end
            OP_LDI:  begin res = DATA_W'(rs);     wr_en = 1'b1; end
            default: begin res = '0;              wr_en = 1'b0; end
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (cond)
            2'd0:    br_taken = 1'b1;
            2'd1:    br_taken = c_flag;
            2'd2:    br_taken = b_flag;
            default: br_taken = z_flag;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
            pc     <= '0;
            dout   <= '0;
            z_flag <= 1'b0;
            b_flag <= 1'b0;
            c_flag <= 1'b0;
            halted <= 1'b0;
        end else if (exec) begin
            if (wr_en) begin
                regs[rd] <= res;
                z_flag   <= (res == '0);
            end
            if (op == OP_ADD) c_flag <= sum[DATA_W];
            if (op == OP_SUB) b_flag <= (a < b);
            if (op == OP_OUT) dout <= a;
            if (op == OP_HALT) begin
                halted <= 1'b1;
            end else if (op == OP_BR && br_taken) begin
                pc <= pc + PC_W'(a);
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    assign flags = {z_flag, b_flag, c_flag};

endmodule

// File: tb/tb_hidden_cpu_param.sv
// Randomised and directed bench for hidden_cpu_param against an integer-arithmetic model of the architecture.
module tb_hidden_cpu_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       instr_valid = 1'b0;
    logic [6:0] instr = '0;
    logic [7:0] pc;
    logic [7:0] dout;
    logic [2:0] flags;
    logic       halted;

    int total = 0;
    int bad   = 0;

    int m_r [4];
    int m_pc, m_dout, m_z, m_b, m_c, m_h;

    hidden_cpu_param #(.DATA_W(8), .NREGS(4), .PC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .dout        (dout),
        .flags       (flags),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},     32'(pc),     32'(m_pc));
        chk({tag, ".dout"},   32'(dout),   32'(m_dout));
        chk({tag, ".flags"},  32'(flags),  32'(m_z * 4 + m_b * 2 + m_c));
        chk({tag, ".halted"}, 32'(halted), 32'(m_h));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = i;
        m_pc = 0; m_dout = 0; m_z = 0; m_b = 0; m_c = 0; m_h = 0;
    endtask

    // Architectural meaning of one instruction, in plain modular arithmetic.
    task automatic model_step(input int v, input int op, input int rd, input int rs);
        int x, y, r;
        bit taken;
        if (m_h != 0 || v == 0) return;
        x = m_r[rd];
        y = m_r[rs];
        m_pc = (m_pc + 1) % 256;
        case (op)
            0: begin r = x + y; m_c = (r > 255); r = r % 256; m_r[rd] = r; m_z = (r == 0); end
            1: begin m_b = (x < y); r = (x - y + 256) % 256; m_r[rd] = r; m_z = (r == 0); end
            2: begin r = 255 - (x & y); m_r[rd] = r; m_z = (r == 0); end
            3: begin m_r[rd] = y; m_z = (y == 0); end
            4: begin m_r[rd] = rs; m_z = (rs == 0); end
            5: begin
                taken = (rs == 0) || (rs == 1 && m_c == 1) || (rs == 2 && m_b == 1) || (rs == 3 && m_z == 1);
                if (taken) m_pc = (m_pc - 1 + x) % 256;
            end
            6: m_dout = x;
            default: begin m_h = 1; m_pc = (m_pc + 255) % 256; end
        endcase
    endtask

    // Called at a negedge; returns at the following negedge with outputs checked.
    task automatic step(input string tag, input int v, input int op, input int rd, input int rs);
        instr_valid = (v != 0);
        instr = {3'(op), 2'(rd), 2'(rs)};
        @(posedge clk);
        model_step(v, op, rd, rs);
        @(negedge clk);
        check_all(tag);
    endtask

    // Mid-cycle asynchronous reset pulse; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic peek_regs(input string tag);
        for (int i = 0; i < 4; i++) step(tag, 1, 6, i, 0);
    endtask

    initial begin
        int op, rd, rs, v;
        model_reset();
        @(negedge clk);
        check_all("rst_hold");
        rst = 1'b1;

        // Execute something, then reset asynchronously and confirm register contents.
        step("pre0", 1, 4, 0, 3);
        step("pre1", 1, 6, 0, 0);
        async_reset("async_rst");
        peek_regs("rst_regs");
        async_reset("async_rst2");

        step("sub_r0_r1", 1, 1, 0, 1);
        chk("sub_pc_const", 32'(pc), 32'd1);
        chk("sub_flags_const", 32'(flags), 32'b010);
        step("add_r0_r1", 1, 0, 0, 1);
        chk("add_flags_const", 32'(flags), 32'b111);
        step("br_c", 1, 5, 3, 1);
        chk("br_c_pc_const", 32'(pc), 32'd5);
        step("nand_r2", 1, 2, 2, 2);
        step("br_z_nt", 1, 5, 3, 3);
        step("br_b", 1, 5, 3, 2);
        peek_regs("arith_regs");

        async_reset("rst_wrap");
        step("sub_r0_r3", 1, 1, 0, 3);
        step("br_to_fe", 1, 5, 0, 0);
        chk("pc_fe_const", 32'(pc), 32'hFE);
        step("br_wrap", 1, 5, 3, 0);
        chk("pc_wrap_const", 32'(pc), 32'h01);

        for (int i = 0; i < 5; i++) step("stall", 0, 0, 0, 1);
        step("out_r2", 1, 6, 2, 0);
        chk("out_r2_const", 32'(dout), 32'h02);

        step("ldi_r1", 1, 4, 1, 3);
        step("add_r1_r1", 1, 0, 1, 1);
        step("out_r1", 1, 6, 1, 0);
        chk("double_const", 32'(dout), 32'd6);
        step("sub_r1_r1", 1, 1, 1, 1);
        step("out_r1b", 1, 6, 1, 0);

        async_reset("rst_halt");
        for (int i = 0; i < 4; i++) step("mov_nop", 1, 3, 0, 0);
        step("halt", 1, 7, 0, 0);
        chk("halt_pc_const", 32'(pc), 32'd4);
        for (int i = 0; i < 10; i++) begin
            op = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 6 : 5);
            step("halted_ignore", int'($urandom_range(0, 1)), op, int'($urandom_range(0, 3)), 0);
        end
        async_reset("rst_unhalt");
        peek_regs("unhalt_regs");

        // Random instruction stream, with occasional halts, resets and register dumps.
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 9) != 0) ? 1 : 0;
            op = int'($urandom_range(0, 6));
            if ($urandom_range(0, 59) == 0) op = 7;
            rd = int'($urandom_range(0, 3));
            rs = int'($urandom_range(0, 3));
            step("rand", v, op, rd, rs);
            if (i % 50 == 49) peek_regs("rand_regs");
            if (m_h != 0 && $urandom_range(0, 3) == 0) begin
                peek_regs("rand_halt_regs");
                async_reset("rand_rst");
            end
        end
        async_reset("final_rst");
        peek_regs("final_regs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
